// File: rtl/note_display_formatter.sv
// note_display_formatter: turns debounced pitch-detector results into a 16-digit hex display word
module note_display_formatter #(
  parameter int         STABLE_COUNT   = 3,
  parameter int         TIMEOUT_CYCLES = 27_000_000,
  parameter int         CENTS_TOL      = 5,
  parameter logic [3:0] FILL           = 4'h0
) (
  input  logic        clock_27mhz,
  input  logic        reset_b,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic [3:0]  note_idx,
  input  logic [3:0]  note_octave,
  input  logic [6:0]  note_cents,
  output logic [63:0] disp_data,
  output logic        disp_update,
  output logic        note_locked,
  output logic        stale
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(STABLE_COUNT + 1);
  // Glyph tables indexed by note_idx, entry 0 in the low nibble; invalid indices map to FILL.
  localparam logic [63:0] LETTERS = {{4{FILL}}, 4'hB, 4'hB, 4'hA, 4'h9, 4'h9, 4'hF, 4'hF,
                                     4'hE, 4'hE, 4'hD, 4'hC, 4'hC};
  localparam logic [63:0] ACCS = {{4{FILL}}, FILL, 4'h8, FILL, 4'h7, FILL, 4'h7, FILL,
                                  FILL, 4'h8, FILL, 4'h7, FILL};

  typedef enum logic [1:0] {IDLE, CHECK, CONV, COMMIT} state_t;

  state_t          state, next;
  logic            xfer, valid_xfer, expired, match;
  logic [3:0]      cap_idx, cap_oct, cand_idx, cand_oct, sign_nib;
  logic [6:0]      cap_cents, cents_mag;
  logic [5:0]      rem, mag_sat;
  logic [2:0]      tens;
  logic            cand_valid;
  logic [SW-1:0]   stable;
  logic [TW-1:0]   to_cnt;
  logic [31:0]     upd_cnt;

  always_comb begin
    note_ready  = (state == IDLE);
    xfer        = note_valid && note_ready;
    valid_xfer  = xfer && (note_idx < 4'd12);
    expired     = (to_cnt >= TW'(TIMEOUT_CYCLES));
    match       = cand_valid && (cap_idx == cand_idx) && (cap_oct == cand_oct);
    note_locked = (stable == SW'(STABLE_COUNT));
    cents_mag   = cap_cents[6] ? 7'(-cap_cents) : cap_cents;
    mag_sat     = (cents_mag > 7'd50) ? 6'd50 : cents_mag[5:0];
    next        = state;
    case (state)
      IDLE:    next = valid_xfer ? CHECK : IDLE;
      CHECK:   next = CONV;
      CONV:    next = (rem < 6'd10) ? COMMIT : CONV;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock_27mhz) state <= !reset_b ? IDLE : next;

  always_ff @(posedge clock_27mhz) begin
    if (!reset_b) begin
      disp_data   <= {16{FILL}};
      disp_update <= 1'b0;
      stale       <= 1'b1;
      upd_cnt     <= '0;
      to_cnt      <= '0;
      cand_valid  <= 1'b0;
      cand_idx    <= '0;
      cand_oct    <= '0;
      stable      <= '0;
      cap_idx     <= '0;
      cap_oct     <= '0;
      cap_cents   <= '0;
      rem         <= '0;
      tens        <= '0;
      sign_nib    <= FILL;
    end else begin
      disp_update <= 1'b0;
      to_cnt      <= valid_xfer ? '0 : (expired ? to_cnt : to_cnt + 1'b1);
      if (valid_xfer) begin
        cap_idx   <= note_idx;
        cap_oct   <= note_octave;
        cap_cents <= note_cents;
      end else if (note_ready && expired) begin
        // Expiry only acts in IDLE, so a deferred expiry lands on the first idle cycle.
        disp_data  <= {16{FILL}};
        stale      <= 1'b1;
        cand_valid <= 1'b0;
        stable     <= '0;
      end
      if (state == CHECK) begin
        cand_valid <= 1'b1;
        cand_idx   <= cap_idx;
        cand_oct   <= cap_oct;
        stable     <= !match ? SW'(1) : (note_locked ? stable : stable + SW'(1));
        rem        <= mag_sat;
        tens       <= '0;
        sign_nib   <= ($signed(cap_cents) > CENTS_TOL) ? 4'h7 :
                      ($signed(cap_cents) < -CENTS_TOL) ? 4'h8 : FILL;
      end
      if (state == CONV && rem >= 6'd10) begin
        rem  <= rem - 6'd10;
        tens <= tens + 3'd1;
      end
      if (state == COMMIT && note_locked) begin
        disp_data   <= {LETTERS[{cap_idx, 2'b00} +: 4], ACCS[{cap_idx, 2'b00} +: 4], cap_oct,
                        FILL, sign_nib, FILL, {1'b0, tens}, rem[3:0], upd_cnt + 32'd1};
        upd_cnt     <= upd_cnt + 32'd1;
        disp_update <= 1'b1;
        stale       <= 1'b0;
      end
    end
  end
endmodule
